fifo_rd_ctrl_fwft: RTL and testbench

FIFO_RD_CTRL_FWFT -- requirements
Module: fifo_rd_ctrl_fwft

---
 rtl/fifo_rd_ctrl_fwft.sv | 135 +++++++++++++
 tb/tb_fifo_rd_ctrl_fwft.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl_fwft.sv
// Read-side controller for a RAM-backed FIFO. It tracks the read pointer against a
// synchronised write pointer and, in FWFT mode, prefetches into a two-entry output buffer.
module fifo_rd_ctrl_fwft #(
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int RD_IND_LOG2    = 2,
  parameter int RD_WIDTH       = 32,
  parameter int FWFT_EN        = 1,
  parameter int AEMPTY_THRESH  = 2,
  localparam int CW            = RAM_ADDR_WIDTH + 1 - RD_IND_LOG2
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst_n,
  input  logic                    rd_en,
  input  logic [RAM_ADDR_WIDTH:0] wr_ptr_sync,
  input  logic [RD_WIDTH-1:0]     ram_rd_data,
  output logic                    ram_rd_en,
  output logic [RAM_ADDR_WIDTH:0] rd_ptr,
  output logic [RD_WIDTH-1:0]     rd_data,
  output logic                    rd_valid,
  output logic                    fifo_empty,
  output logic                    almost_empty,
  output logic [CW:0]             rd_data_count,
  output logic                    underflow
);

  localparam int PW = RAM_ADDR_WIDTH + 1;
  localparam logic [RAM_ADDR_WIDTH:0] PTR_STEP = PW'(1 << RD_IND_LOG2);
  localparam logic [CW:0] AE_LIMIT = (CW+1)'(AEMPTY_THRESH);

  logic [RAM_ADDR_WIDTH:0] ram_cnt;
  logic [CW-1:0]           ram_words;
  logic                    ram_empty;

  // Modular subtraction covers pointer wrap; the extra MSB keeps a full RAM distinct from empty.
  assign ram_cnt   = wr_ptr_sync - rd_ptr;
  assign ram_words = CW'(ram_cnt >> RD_IND_LOG2);
  assign ram_empty = (ram_words == '0);

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_ptr <= '0;
    end else if (ram_rd_en) begin
      rd_ptr <= rd_ptr + PTR_STEP;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      underflow <= 1'b0;
    end else begin
      underflow <= rd_en & fifo_empty;
    end
  end

  assign almost_empty = (rd_data_count <= AE_LIMIT);

  if (FWFT_EN != 0) begin : g_fwft
    logic                head_valid, tail_valid, pend;
    logic [RD_WIDTH-1:0] head_data, tail_data;
    logic                head_valid_n, tail_valid_n;
    logic [RD_WIDTH-1:0] head_data_n, tail_data_n;
    logic [1:0]          occ;
    logic                pop;

    assign occ = 2'(head_valid) + 2'(tail_valid) + 2'(pend);
    assign pop = rd_en & head_valid;

    // Only issue a read when the buffer can still absorb it after this cycle's pop.
    assign ram_rd_en = rd_rst_n & ~ram_empty & ((occ - 2'(pop)) < 2'd2);

    always_comb begin
      head_valid_n = head_valid;
      head_data_n  = head_data;
      tail_valid_n = tail_valid;
      tail_data_n  = tail_data;
      if (pop) begin
        head_valid_n = tail_valid;
        if (tail_valid) begin
          head_data_n = tail_data;
        end
        tail_valid_n = 1'b0;
      end
      if (pend) begin
        if (!head_valid_n) begin
          head_valid_n = 1'b1;
          head_data_n  = ram_rd_data;
        end else begin
          tail_valid_n = 1'b1;
          tail_data_n  = ram_rd_data;
        end
      end
    end

    // Clearing pend on reset drops any RAM word still in flight.
    always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
        head_valid <= 1'b0;
        tail_valid <= 1'b0;
        pend       <= 1'b0;
        head_data  <= '0;
        tail_data  <= '0;
      end else begin
        head_valid <= head_valid_n;
        tail_valid <= tail_valid_n;
        pend       <= ram_rd_en;
        head_data  <= head_data_n;
        tail_data  <= tail_data_n;
      end
    end

    assign rd_valid      = head_valid;
    assign rd_data       = head_data;
    assign fifo_empty    = ~head_valid;
    assign rd_data_count = (CW+1)'(ram_words) + (CW+1)'(occ);
  end else begin : g_std
    logic valid_q;

    assign ram_rd_en = rd_rst_n & rd_en & ~ram_empty;

    always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= ram_rd_en;
      end
    end

    // Masking keeps rd_data at zero after reset instead of showing stale RAM output.
    assign rd_valid      = valid_q;
    assign rd_data       = valid_q ? ram_rd_data : '0;
    assign fifo_empty    = ram_empty;
    assign rd_data_count = {1'b0, ram_words};
  end

endmodule

// File: tb/tb_fifo_rd_ctrl_fwft.sv
// Directed bench for fifo_rd_ctrl_fwft: a vector table for single-cycle behaviour plus
// hand-written sequences for burst, pointer wrap, standard mode and reset with a read in flight.
module tb_fifo_rd_ctrl_fwft;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          rd_en;
  logic [AW:0]   wr_ptr_sync;
  logic [DW-1:0] ram_rd_data;
  logic          ram_rd_en;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          fifo_empty;
  logic          almost_empty;
  logic [4:0]    rd_data_count;
  logic          underflow;

  logic          std_rd_en;
  logic [AW:0]   std_wr_ptr;
  logic [DW-1:0] std_ram_rd_data;
  logic          std_ram_rd_en;
  logic [AW:0]   std_rd_ptr;
  logic [DW-1:0] std_rd_data;
  logic          std_rd_valid;
  logic          std_fifo_empty;
  logic          std_almost_empty;
  logic [4:0]    std_count;
  logic          std_underflow;

  int checks = 0;
  int errors = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl_fwft dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .rd_en(rd_en), .wr_ptr_sync(wr_ptr_sync),
    .ram_rd_data(ram_rd_data), .ram_rd_en(ram_rd_en), .rd_ptr(rd_ptr), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_empty(fifo_empty), .almost_empty(almost_empty),
    .rd_data_count(rd_data_count), .underflow(underflow)
  );

  fifo_rd_ctrl_fwft #(.FWFT_EN(0)) dut_std (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .rd_en(std_rd_en), .wr_ptr_sync(std_wr_ptr),
    .ram_rd_data(std_ram_rd_data), .ram_rd_en(std_ram_rd_en), .rd_ptr(std_rd_ptr),
    .rd_data(std_rd_data), .rd_valid(std_rd_valid), .fifo_empty(std_fifo_empty),
    .almost_empty(std_almost_empty), .rd_data_count(std_count), .underflow(std_underflow)
  );

  // RAM models: one-cycle read latency, each location holds CAFE0000 plus its address.
  always @(posedge rd_clk) begin
    if (ram_rd_en) ram_rd_data <= 32'hCAFE_0000 | {27'd0, rd_ptr[4:0]};
    if (std_ram_rd_en) std_ram_rd_data <= 32'hCAFE_0000 | {27'd0, std_rd_ptr[4:0]};
  end

  typedef struct {
    logic        rst_n;
    logic        rd_en;
    logic [5:0]  wr;
    logic        exp_rre;
    logic [5:0]  exp_ptr;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_empty;
    logic        exp_ae;
    logic [4:0]  exp_cnt;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic rst_n, logic ren, logic [5:0] wr, logic rre, logic [5:0] ptr,
                              logic valid, logic chkd, logic [31:0] data, logic empty, logic ae,
                              logic [4:0] cnt, logic uf);
    vec_t v;
    v.rst_n = rst_n; v.rd_en = ren; v.wr = wr; v.exp_rre = rre; v.exp_ptr = ptr;
    v.exp_valid = valid; v.chk_data = chkd; v.exp_data = data; v.exp_empty = empty;
    v.exp_ae = ae; v.exp_cnt = cnt; v.exp_uf = uf;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rd_rst_n    = v.rst_n;
    rd_en       = v.rd_en;
    wr_ptr_sync = v.wr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, first_c, last_c;
    logic done;
    logic [4:0] a;

    // rst, rd_en, wr | ram_rd_en, ptr, valid, chk_data, data, empty, ae, cnt, uf
    vecs[0]  = mk(1, 0, 0,  0, 0,  0, 1, 32'h0,          1, 1, 0, 0);
    vecs[1]  = mk(1, 1, 0,  0, 0,  0, 1, 32'h0,          1, 1, 0, 0);
    vecs[2]  = mk(1, 0, 4,  1, 0,  0, 1, 32'h0,          1, 1, 1, 1);
    vecs[3]  = mk(1, 0, 4,  0, 4,  0, 1, 32'h0,          1, 1, 1, 0);
    vecs[4]  = mk(1, 0, 4,  0, 4,  1, 1, 32'hCAFE_0000,  0, 1, 1, 0);
    vecs[5]  = mk(1, 1, 4,  0, 4,  1, 1, 32'hCAFE_0000,  0, 1, 1, 0);
    vecs[6]  = mk(1, 0, 4,  0, 4,  0, 0, 32'h0,          1, 1, 0, 0);
    vecs[7]  = mk(1, 0, 16, 1, 4,  0, 0, 32'h0,          1, 0, 3, 0);
    vecs[8]  = mk(1, 0, 16, 1, 8,  0, 0, 32'h0,          1, 0, 3, 0);
    vecs[9]  = mk(1, 0, 16, 0, 12, 1, 1, 32'hCAFE_0004,  0, 0, 3, 0);
    vecs[10] = mk(1, 0, 16, 0, 12, 1, 1, 32'hCAFE_0004,  0, 0, 3, 0);
    vecs[11] = mk(1, 1, 16, 1, 12, 1, 1, 32'hCAFE_0004,  0, 0, 3, 0);
    vecs[12] = mk(1, 1, 16, 0, 16, 1, 1, 32'hCAFE_0008,  0, 1, 2, 0);
    vecs[13] = mk(1, 1, 16, 0, 16, 1, 1, 32'hCAFE_000C,  0, 1, 1, 0);
    vecs[14] = mk(1, 1, 16, 0, 16, 0, 0, 32'h0,          1, 1, 0, 0);
    vecs[15] = mk(1, 0, 16, 0, 16, 0, 0, 32'h0,          1, 1, 0, 1);
    vecs[16] = mk(1, 0, 16, 0, 16, 0, 0, 32'h0,          1, 1, 0, 0);

    $display("[TB] reset");
    rd_rst_n = 1'b0; rd_en = 1'b0; wr_ptr_sync = 6'd8;
    std_rd_en = 1'b0; std_wr_ptr = 6'd0;
    repeat (2) @(posedge rd_clk);
    #1;
    checkOutput("rst_ram_rd_en", ram_rd_en, 0);
    checkOutput("rst_ptr", rd_ptr, 0);
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_data", rd_data, 0);
    wr_ptr_sync = 6'd0;
    rd_rst_n = 1'b1;
    @(posedge rd_clk); #1;

    $display("[TB] standard mode");
    std_rd_en = 1'b1;
    #1;
    checkOutput("std_empty_rre", std_ram_rd_en, 0);
    checkOutput("std_empty", std_fifo_empty, 1);
    @(posedge rd_clk); #1;
    std_rd_en = 1'b0;
    checkOutput("std_uf_pulse", std_underflow, 1);
    checkOutput("std_uf_ptr", std_rd_ptr, 0);
    @(posedge rd_clk); #1;
    checkOutput("std_uf_clear", std_underflow, 0);
    std_wr_ptr = 6'd4; std_rd_en = 1'b1;
    #1;
    checkOutput("std_rre", std_ram_rd_en, 1);
    checkOutput("std_cnt", std_count, 1);
    @(posedge rd_clk); #1;
    std_rd_en = 1'b0;
    checkOutput("std_ptr", std_rd_ptr, 4);
    checkOutput("std_valid", std_rd_valid, 1);
    checkOutput("std_data", std_rd_data, 32'hCAFE_0000);
    @(posedge rd_clk); #1;
    checkOutput("std_valid_drop", std_rd_valid, 0);

    $display("[TB] FWFT vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_rre", i), ram_rd_en, vecs[i].exp_rre);
      checkOutput($sformatf("v%0d_ptr", i), rd_ptr, vecs[i].exp_ptr);
      checkOutput($sformatf("v%0d_valid", i), rd_valid, vecs[i].exp_valid);
      if (vecs[i].chk_data) checkOutput($sformatf("v%0d_data", i), rd_data, vecs[i].exp_data);
      checkOutput($sformatf("v%0d_empty", i), fifo_empty, vecs[i].exp_empty);
      checkOutput($sformatf("v%0d_ae", i), almost_empty, vecs[i].exp_ae);
      checkOutput($sformatf("v%0d_cnt", i), rd_data_count, vecs[i].exp_cnt);
      checkOutput($sformatf("v%0d_uf", i), underflow, vecs[i].exp_uf);
      @(posedge rd_clk); #1;
    end

    $display("[TB] FWFT burst of 8 words");
    wr_ptr_sync = 6'd48; rd_en = 1'b1;
    k = 0; first_c = -1; last_c = -1;
    #1;
    checkOutput("burst_full_cnt", rd_data_count, 8);
    for (int c = 0; c < 40 && k < 8; c++) begin
      if (c > 0) #1;
      if (rd_valid) begin
        a = 5'(16 + 4 * k);
        checkOutput($sformatf("burst_w%0d", k), rd_data, 32'hCAFE_0000 | {27'd0, a});
        if (k == 0) first_c = c;
        last_c = c;
        k++;
      end
      @(posedge rd_clk); #1;
    end
    rd_en = 1'b0;
    checkOutput("burst_words", k, 8);
    checkOutput("burst_first_lat", first_c, 2);
    checkOutput("burst_span", last_c - first_c, 7);
    #1;
    checkOutput("burst_empty", fifo_empty, 1);
    checkOutput("burst_cnt", rd_data_count, 0);
    checkOutput("burst_ptr", rd_ptr, 48);

    $display("[TB] pointer wrap");
    @(posedge rd_clk); #1;
    wr_ptr_sync = 6'd60; rd_en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge rd_clk); #1;
      if (rd_ptr == 6'd60 && fifo_empty) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("wrap_drain", done, 1);
    rd_en = 1'b0; wr_ptr_sync = 6'd4;
    #1;
    checkOutput("wrap_cnt", rd_data_count, 2);
    checkOutput("wrap_rre", ram_rd_en, 1);
    repeat (3) @(posedge rd_clk);
    #1;
    checkOutput("wrap_ptr", rd_ptr, 4);
    checkOutput("wrap_cnt_hold", rd_data_count, 2);
    checkOutput("wrap_rre_idle", ram_rd_en, 0);
    checkOutput("wrap_valid", rd_valid, 1);
    checkOutput("wrap_data0", rd_data, 32'hCAFE_001C);
    rd_en = 1'b1;
    @(posedge rd_clk); #1;
    checkOutput("wrap_data1", rd_data, 32'hCAFE_0000);
    checkOutput("wrap_cnt1", rd_data_count, 1);
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    checkOutput("wrap_empty", fifo_empty, 1);

    $display("[TB] reset with read in flight");
    @(posedge rd_clk); #1;
    wr_ptr_sync = 6'd8;
    #1;
    checkOutput("inflight_rre", ram_rd_en, 1);
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b0; wr_ptr_sync = 6'd0;
    #1;
    checkOutput("inrst_rre", ram_rd_en, 0);
    @(posedge rd_clk); #1;
    checkOutput("postrst_valid", rd_valid, 0);
    checkOutput("postrst_ptr", rd_ptr, 0);
    checkOutput("postrst_data", rd_data, 0);
    rd_rst_n = 1'b1;
    @(posedge rd_clk); #1;
    checkOutput("stale_valid", rd_valid, 0);
    checkOutput("stale_empty", fifo_empty, 1);
    checkOutput("stale_cnt", rd_data_count, 0);
    checkOutput("stale_ae", almost_empty, 1);
    checkOutput("stale_uf", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
